// File: rtl/uart_core_param.sv
// uart_core_param: parametrised UART transceiver with configurable frame
// format (data width, parity, stop bits) and a small TX FIFO. RX and TX
// run independently on the same clock.
module uart_core_param #(
   parameter int DATA_BITS     = 8,
   parameter int CLKS_PER_BIT  = 48,
   parameter int PARITY_MODE   = 0,
   parameter int STOP_BITS     = 1,
   parameter int TX_FIFO_DEPTH = 4
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 SerDataIn,
   output logic [DATA_BITS:0]   PalDataOut,
   output logic                 PalDataOutValid,
   output logic                 ParityErr,
   output logic                 FrameErr,
   input  logic [DATA_BITS-1:0] PalDataIn,
   input  logic                 PalDataInEn,
   output logic                 PalDataInPermit,
   output logic                 SerDataOut,
   output logic                 TxBusy
);

   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int PTR_W  = $clog2(TX_FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(TX_FIFO_DEPTH);
   localparam bit                HAS_PAR   = (PARITY_MODE != 0);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // Parity bit that makes the data-plus-parity population odd (mode 1) or even (mode 2).
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
      return (PARITY_MODE == 1) ? ~(^d) : (^d);
   endfunction

   // ---------------- receiver ----------------
   logic [1:0]           rx_sync_q;
   logic                 rx_last_q;
   logic                 rx_line;
   state_t               rx_state_q, rx_state_d;
   logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
   logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
   logic                 rx_stop_q, rx_stop_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic [DATA_BITS:0]   out_data_q, out_data_d;
   logic                 valid_q, valid_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;

   assign rx_line = rx_sync_q[1];

   // Two-flop synchroniser on the serial input plus a delayed copy for edge detection.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_sync_q <= 2'b11;
         rx_last_q <= 1'b1;
      end else begin
         rx_sync_q <= {rx_sync_q[0], SerDataIn};
         rx_last_q <= rx_line;
      end
   end

   // RX next-state: find start edge, confirm at mid-bit, then sample each bit at its centre.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_stop_d  = rx_stop_q;
      rx_shift_d = rx_shift_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      out_data_d = out_data_q;
      valid_d    = 1'b0;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      case (rx_state_q)
         ST_IDLE: begin
            if (rx_last_q && !rx_line) begin
               rx_state_d = ST_START;
               rx_cnt_d   = '0;
            end
         end
         ST_START: begin
            if (rx_cnt_q == CNT_MID) begin
               rx_cnt_d = '0;
               if (!rx_line) begin
                  rx_state_d = ST_DATA;
                  rx_bit_d   = '0;
                  rx_stop_d  = 1'b0;
                  rx_perr_d  = 1'b0;
                  rx_ferr_d  = 1'b0;
               end else begin
                  rx_state_d = ST_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == BIT_LAST) begin
                  rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + BIT_W'(1);
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         ST_PARITY: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_perr_d  = (rx_line != parity_bit(rx_shift_q));
               rx_state_d = ST_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               if (rx_stop_q == STOP_LAST) begin
                  // Going idle at mid stop bit lets a back-to-back start edge be caught.
                  rx_state_d = ST_IDLE;
                  valid_d    = 1'b1;
                  perr_out_d = rx_perr_q;
                  ferr_out_d = rx_ferr_q | !rx_line;
                  out_data_d = {rx_perr_q | rx_ferr_q | !rx_line, rx_shift_q};
               end else begin
                  rx_stop_d = rx_stop_q + 1'b1;
                  rx_ferr_d = rx_ferr_q | !rx_line;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   // RX state register; the shift register is pure data and is not reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_stop_q  <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         out_data_q <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_stop_q  <= rx_stop_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         out_data_q <= out_data_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
      end
      rx_shift_q <= rx_shift_d;
   end

   assign PalDataOut      = out_data_q;
   assign PalDataOutValid = valid_q;
   assign ParityErr       = perr_out_q;
   assign FrameErr        = ferr_out_q;

   // ---------------- transmitter ----------------
   logic [DATA_BITS-1:0] fifo_mem_q [TX_FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic                 push, pop;
   state_t               tx_state_q, tx_state_d;
   logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
   logic                 tx_stop_q, tx_stop_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 ser_q, ser_d;

   // TX next-state and FIFO bookkeeping; a pop loads the shifter and starts a frame.
   always_comb begin
      push       = PalDataInEn && (fifo_cnt_q != FIFO_FULL);
      pop        = 1'b0;
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_stop_d  = tx_stop_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      ser_d      = ser_q;
      case (tx_state_q)
         ST_IDLE: begin
            if (fifo_cnt_q != '0) begin
               pop        = 1'b1;
               tx_state_d = ST_START;
               tx_cnt_d   = '0;
               ser_d      = 1'b0;
            end
         end
         ST_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = ST_DATA;
               ser_d      = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == BIT_LAST) begin
                  tx_stop_d = 1'b0;
                  if (HAS_PAR) begin
                     tx_state_d = ST_PARITY;
                     ser_d      = tx_par_q;
                  end else begin
                     tx_state_d = ST_STOP;
                     ser_d      = 1'b1;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + BIT_W'(1);
                  tx_shift_d = tx_shift_q >> 1;
                  ser_d      = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         ST_PARITY: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_stop_d  = 1'b0;
               tx_state_d = ST_STOP;
               ser_d      = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_stop_q == STOP_LAST) begin
                  if (fifo_cnt_q != '0) begin
                     pop        = 1'b1;
                     tx_state_d = ST_START;
                     ser_d      = 1'b0;
                  end else begin
                     tx_state_d = ST_IDLE;
                  end
               end else begin
                  tx_stop_d = tx_stop_q + 1'b1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
      if (pop) begin
         tx_shift_d = fifo_mem_q[rd_ptr_q];
         tx_par_d   = parity_bit(fifo_mem_q[rd_ptr_q]);
      end
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
   end

   // TX state and FIFO pointers; FIFO storage and shifter are data and are not reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_stop_q  <= 1'b0;
         ser_q      <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_stop_q  <= tx_stop_d;
         ser_q      <= ser_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= PalDataIn;
      end
   end

   assign PalDataInPermit = (fifo_cnt_q != FIFO_FULL);
   assign SerDataOut      = ser_q;
   assign TxBusy          = (tx_state_q != ST_IDLE) || (fifo_cnt_q != '0);

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: three instances cover the default 8N1
// configuration (with optional loopback), 7-bit even parity, and two stop bits.
module tb_uart_core_param;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       rx_drv;
   logic [1:0] rx_sel;
   logic       loop_a;
   int         n_cmp = 0;
   int         n_bad = 0;

   logic [8:0] dout_a, cap_a;
   logic       vld_a, perr_a, ferr_a, perm_a, sout_a, busy_a, en_a, sin_a;
   logic [7:0] din_a;
   int         vcnt_a = 0;

   logic [7:0] dout_b, cap_b;
   logic       vld_b, perr_b, ferr_b, perm_b, sout_b, busy_b, sin_b;
   logic [6:0] din_b;
   int         vcnt_b = 0;

   logic [8:0] dout_c, cap_c;
   logic       vld_c, perr_c, ferr_c, perm_c, sout_c, busy_c, en_c, sin_c;
   logic [7:0] din_c;
   int         vcnt_c = 0;

   always #5 Clk = ~Clk;

   assign sin_a = (rx_sel == 2'd0) ? (loop_a ? sout_a : rx_drv) : 1'b1;
   assign sin_b = (rx_sel == 2'd1) ? rx_drv : 1'b1;
   assign sin_c = (rx_sel == 2'd2) ? rx_drv : 1'b1;
   assign din_b = 7'h00;

   uart_core_param u_a (
      .Clk(Clk), .Rst(Rst), .SerDataIn(sin_a), .PalDataOut(dout_a),
      .PalDataOutValid(vld_a), .ParityErr(perr_a), .FrameErr(ferr_a),
      .PalDataIn(din_a), .PalDataInEn(en_a), .PalDataInPermit(perm_a),
      .SerDataOut(sout_a), .TxBusy(busy_a)
   );

   uart_core_param #(.DATA_BITS(7), .PARITY_MODE(2)) u_b (
      .Clk(Clk), .Rst(Rst), .SerDataIn(sin_b), .PalDataOut(dout_b),
      .PalDataOutValid(vld_b), .ParityErr(perr_b), .FrameErr(ferr_b),
      .PalDataIn(din_b), .PalDataInEn(1'b0), .PalDataInPermit(perm_b),
      .SerDataOut(sout_b), .TxBusy(busy_b)
   );

   uart_core_param #(.STOP_BITS(2)) u_c (
      .Clk(Clk), .Rst(Rst), .SerDataIn(sin_c), .PalDataOut(dout_c),
      .PalDataOutValid(vld_c), .ParityErr(perr_c), .FrameErr(ferr_c),
      .PalDataIn(din_c), .PalDataInEn(en_c), .PalDataInPermit(perm_c),
      .SerDataOut(sout_c), .TxBusy(busy_c)
   );

   // Count receive pulses and capture the delivered word, away from the active edge.
   always @(negedge Clk) begin
      if (vld_a) begin vcnt_a = vcnt_a + 1; cap_a = dout_a; end
      if (vld_b) begin vcnt_b = vcnt_b + 1; cap_b = dout_b; end
      if (vld_c) begin vcnt_c = vcnt_c + 1; cap_c = dout_c; end
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level of bit k of an 8-bit frame: start, 8 data LSB first, then stop(s).
   function automatic logic exp8n1(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   task automatic send_frame(input logic [1:0] sel, input logic [15:0] bits, input int n);
      rx_sel = sel;
      for (int i = 0; i < n; i++) begin
         rx_drv = bits[i];
         repeat (48) @(posedge Clk);
         #1;
      end
      rx_drv = 1'b1;
   endtask

   // Write one byte to instance a and check its line and TxBusy every cycle of the frame.
   task automatic tx_one_a(input logic [7:0] b);
      en_a = 1'b1; din_a = b;
      @(posedge Clk); #1;
      en_a = 1'b0;
      for (int c = 0; c < 490; c++) begin
         @(posedge Clk); @(negedge Clk);
         chk_eq("tx_line", sout_a, (c < 480) ? exp8n1(b, c / 48) : 1'b1);
         chk_eq("tx_busy", busy_a, (c < 480) ? 1 : 0);
      end
      @(posedge Clk); #1;
   endtask

   initial begin
      int base;
      logic [15:0] f;
      Rst = 1'b1; rx_drv = 1'b1; rx_sel = 2'd0; loop_a = 1'b0;
      en_a = 1'b0; din_a = 8'h00; en_c = 1'b0; din_c = 8'h00;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk_eq("rst_dout",   dout_a, 0);
      chk_eq("rst_valid",  vld_a, 0);
      chk_eq("rst_perr",   perr_a, 0);
      chk_eq("rst_ferr",   ferr_a, 0);
      chk_eq("rst_permit", perm_a, 1);
      chk_eq("rst_sout",   sout_a, 1);
      chk_eq("rst_busy",   busy_a, 0);
      Rst = 1'b0;
      @(posedge Clk); #1;

      // Default 8N1 loopback of 0xA5
      loop_a = 1'b1;
      base = vcnt_a;
      tx_one_a(8'hA5);
      repeat (20) @(posedge Clk); #1;
      chk_eq("lb_vcnt", vcnt_a - base, 1);
      chk_eq("lb_data", cap_a, 9'h0A5);
      chk_eq("lb_perr", perr_a, 0);
      chk_eq("lb_ferr", ferr_a, 0);
      loop_a = 1'b0;

      // 7-bit even parity: 0x41 has two ones, so the correct parity bit is 0
      base = vcnt_b;
      f = {6'h3F, 1'b1, 1'b1, 7'h41, 1'b0};
      send_frame(2'd1, f, 10);
      repeat (10) @(posedge Clk); #1;
      chk_eq("par_bad_vcnt", vcnt_b - base, 1);
      chk_eq("par_bad_data", cap_b[6:0], 7'h41);
      chk_eq("par_bad_flag", cap_b[7], 1);
      chk_eq("par_bad_perr", perr_b, 1);
      chk_eq("par_bad_ferr", ferr_b, 0);
      f = {6'h3F, 1'b1, 1'b0, 7'h41, 1'b0};
      send_frame(2'd1, f, 10);
      repeat (10) @(posedge Clk); #1;
      chk_eq("par_ok_vcnt", vcnt_b - base, 2);
      chk_eq("par_ok_data", cap_b, 8'h41);
      chk_eq("par_ok_perr", perr_b, 0);

      // Low stop bit on 0x3C, then a short glitch on the idle line
      base = vcnt_a;
      f = {6'h3F, 1'b0, 8'h3C, 1'b0};
      send_frame(2'd0, f, 10);
      repeat (100) @(posedge Clk); #1;
      chk_eq("fe_vcnt", vcnt_a - base, 1);
      chk_eq("fe_data", cap_a, 9'h13C);
      chk_eq("fe_ferr", ferr_a, 1);
      chk_eq("fe_perr", perr_a, 0);
      rx_drv = 1'b0;
      repeat (20) @(posedge Clk); #1;
      rx_drv = 1'b1;
      repeat (200) @(posedge Clk); #1;
      chk_eq("glitch_vcnt", vcnt_a - base, 1);
      chk_eq("glitch_ferr_held", ferr_a, 1);

      // Six back-to-back writes: first pops at once, four fill the FIFO, sixth dropped
      for (int i = 0; i < 6; i++) begin
         chk_eq("fifo_permit_wr", perm_a, (i < 5) ? 1 : 0);
         en_a = 1'b1; din_a = 8'(i + 1);
         @(posedge Clk); #1;
      end
      en_a = 1'b0;
      for (int c = 4; c < 2410; c++) begin
         @(negedge Clk);
         chk_eq("fifo_line", sout_a, (c < 2400) ? exp8n1(8'(c / 480 + 1), (c % 480) / 48) : 1'b1);
         chk_eq("fifo_busy", busy_a, (c < 2400) ? 1 : 0);
         chk_eq("fifo_permit", perm_a, (c < 480) ? 0 : 1);
      end
      @(posedge Clk); #1;

      // Two stop bits: second stop low flags a framing error, then a clean frame
      base = vcnt_c;
      f = {5'h1F, 1'b0, 1'b1, 8'h5A, 1'b0};
      send_frame(2'd2, f, 11);
      repeat (10) @(posedge Clk); #1;
      chk_eq("st2_bad_vcnt", vcnt_c - base, 1);
      chk_eq("st2_bad_data", cap_c, 9'h15A);
      chk_eq("st2_bad_ferr", ferr_c, 1);
      f = {5'h1F, 1'b1, 1'b1, 8'h5A, 1'b0};
      send_frame(2'd2, f, 11);
      repeat (10) @(posedge Clk); #1;
      chk_eq("st2_ok_vcnt", vcnt_c - base, 2);
      chk_eq("st2_ok_data", cap_c, 9'h05A);
      chk_eq("st2_ok_ferr", ferr_c, 0);
      en_c = 1'b1; din_c = 8'h81;
      @(posedge Clk); #1;
      en_c = 1'b0;
      for (int c = 0; c < 540; c++) begin
         @(posedge Clk); @(negedge Clk);
         chk_eq("st2_line", sout_c, (c < 528) ? exp8n1(8'h81, c / 48) : 1'b1);
         chk_eq("st2_busy", busy_c, (c < 528) ? 1 : 0);
      end
      @(posedge Clk); #1;

      // Reset 200 cycles into both a TX frame (with a second byte queued) and an RX frame
      base = vcnt_a;
      rx_sel = 2'd0;
      f = {6'h3F, 1'b1, 8'h12, 1'b0};
      en_a = 1'b1; din_a = 8'h55;
      for (int c = 0; c < 200; c++) begin
         rx_drv = f[c / 48];
         if (c == 1) din_a = 8'h66;
         if (c == 2) en_a = 1'b0;
         @(posedge Clk); #1;
      end
      Rst = 1'b1; rx_drv = 1'b1;
      @(posedge Clk); @(negedge Clk);
      chk_eq("mid_rst_sout",   sout_a, 1);
      chk_eq("mid_rst_permit", perm_a, 1);
      chk_eq("mid_rst_busy",   busy_a, 0);
      chk_eq("mid_rst_valid",  vld_a, 0);
      chk_eq("mid_rst_dout",   dout_a, 0);
      chk_eq("mid_rst_ferr",   ferr_a, 0);
      chk_eq("mid_rst_perr",   perr_a, 0);
      Rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         repeat (100) @(posedge Clk);
         @(negedge Clk);
         chk_eq("post_rst_sout", sout_a, 1);
         chk_eq("post_rst_busy", busy_a, 0);
      end
      chk_eq("post_rst_vcnt", vcnt_a - base, 0);
      @(posedge Clk); #1;
      loop_a = 1'b1;
      tx_one_a(8'h3C);
      repeat (20) @(posedge Clk); #1;
      chk_eq("post_rst_lb_vcnt", vcnt_a - base, 1);
      chk_eq("post_rst_lb_data", cap_a, 9'h03C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised UART transceiver; next generation of the fixed 8N1 serial core on the 12.288 MHz domain. Adds configurable data width, parity and stop-bit modes, and a TX FIFO with back-pressure. RX reports parity and framing errors per character. Sits between the serial pins and the parallel host-side logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
CLKS_PER_BIT, 48, Clk cycles per bit (12.288 MHz / 256000 bps); legal >= 8.
PARITY_MODE, 0, 0 none, 1 odd, 2 even.
STOP_BITS, 1, 1 or 2.
TX_FIFO_DEPTH, 4, TX FIFO entries, power of 2, >= 2.

Ports:
Clk  in  1  system clock, all logic on rising edge.
Rst  in  1  synchronous active-high reset.
SerDataIn  in  1  serial RX line, idle high, asynchronous to Clk.
PalDataOut  out  DATA_BITS+1  [DATA_BITS-1:0] received data; [DATA_BITS] = error flag (ParityErr | FrameErr).
PalDataOutValid  out  1  one-cycle pulse; PalDataOut, ParityErr and FrameErr valid on it.
ParityErr  out  1  parity mismatch on the current character, held until the next Valid.
FrameErr  out  1  stop bit sampled low, held until the next Valid.
PalDataIn  in  DATA_BITS  TX write data.
PalDataInEn  in  1  TX write strobe.
PalDataInPermit  out  1  TX FIFO not full; write accepted only when En && Permit.
SerDataOut  out  1  serial TX line, idle high.
TxBusy  out  1  high while the TX FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (Rst high at a Clk edge) takes effect at that edge, including mid-frame:
  - all outputs take reset values: PalDataOut=0, Valid=0, ParityErr=0, FrameErr=0, Permit=1, SerDataOut=1, TxBusy=0.
  - the FIFO is emptied; both FSMs go to IDLE; the RX synchroniser is set to 1.
  - a partial RX character produces no Valid.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1). Each bit is exactly CLKS_PER_BIT cycles.
- Parity: odd means the count of data bits plus the parity bit is odd; even means that count is even.
- RX synchroniser: 2-FF on SerDataIn, giving 2 cycles of latency. All RX decisions use the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a high-to-low transition of the synchronised line.
  - START: count CLKS_PER_BIT/2 cycles (integer division) to reach mid-bit, then resample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles from mid-start; shift in DATA_BITS bits LSB first.
  - PARITY (skipped if PARITY_MODE=0): sample the bit and compare with the computed parity.
  - STOP: sample each stop bit mid-bit; any 0 sets FrameErr.
  - On the cycle after the final stop-bit sample: pulse Valid for 1 cycle, load PalDataOut and the error flags, go to IDLE.
  - The receiver re-arms immediately and accepts a start edge during the second half of the final stop bit. This tolerates back-to-back frames.
- TX FIFO: synchronous, registered count.
  - Permit = (count != TX_FIFO_DEPTH), derived from registered state only.
  - A write with Permit=0 is dropped; stored data is never overwritten.
  - Simultaneous write and pop leaves the count unchanged.
  - When full, a pop in the same cycle does not make a write in that cycle legal.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with the FIFO non-empty: pop at that edge; SerDataOut drives the start bit from the next cycle.
  - Each bit is held CLKS_PER_BIT cycles; PARITY is skipped when PARITY_MODE=0.
  - At the end of the last stop bit, if the FIFO is non-empty, go directly to START with zero idle cycles; otherwise go to IDLE.
  - Write-to-start latency from an empty, idle FIFO: 2 cycles (write edge, pop edge, start bit on the line).
- SerDataOut is registered and glitch-free. RX and TX are fully independent, so loopback works with SerDataOut tied to SerDataIn.

Test Plan:
- Defaults, loopback; write 0xA5 -> SerDataOut low for 48 cycles, then bits 1,0,1,0,0,1,0,1, then high for 48 cycles. Valid pulses once with PalDataOut=9'h0A5.
- PARITY_MODE=2, DATA_BITS=7: drive 0x41 with a wrong parity bit -> Valid with PalDataOut[6:0]=0x41, ParityErr=1, PalDataOut[7]=1. Correct parity -> ParityErr=0.
- Drive the stop bit low on 0x3C -> FrameErr=1, data 0x3C. Then send a 20-cycle low glitch on an idle line -> no Valid.
- Write 6 bytes 0x01..0x06 back-to-back with TX_FIFO_DEPTH=4 while TX is busy:
  - Permit falls after 4 FIFO entries.
  - Excess writes are dropped.
  - Accepted bytes go out in order with no idle gap.
  - TxBusy stays high throughout.
- STOP_BITS=2: frame is 11 bits (528 cycles). A second stop bit sampled low -> FrameErr=1.
- Assert Rst at cycle 200 of a TX frame and of an RX frame -> SerDataOut=1 on the next edge, FIFO empty, Permit=1, no Valid. Next frame received correctly.
